// File: rtl/ravenoc_pkg.sv
// Shared flit-format definitions and arbiter state encoding for the router output stage.
package ravenoc_pkg;
    localparam int FLIT_W   = 34;
    localparam int VC_ID_W  = 2;

    localparam logic [1:0] HEAD_FLIT = 2'b00;
    localparam logic [1:0] BODY_FLIT = 2'b01;
    localparam logic [1:0] TAIL_FLIT = 2'b11;
    localparam logic [1:0] RSVD_FLIT = 2'b10;

    localparam int TYPE_MSB = 33;
    localparam int TYPE_LSB = 32;
    localparam int SIZE_MSB = 29;
    localparam int SIZE_LSB = 22;

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } arb_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after i_ptr
// (wrapping modulo N) wins; nothing is granted while i_en is low.
module rr_arbiter
    import ravenoc_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [N-1:0]         i_req,
    input  logic [VC_ID_W-1:0]   i_ptr,
    input  logic                 i_en,
    output logic [N-1:0]         o_gnt,
    output logic [VC_ID_W-1:0]   o_idx
);
    always_comb begin
        logic [VC_ID_W:0] w_sum;
        logic             w_found;
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_sum   = '0;
        for (int k = 0; k < N; k++) begin
            // i_ptr < N and k < N, so one subtraction is enough to wrap
            w_sum = {1'b0, i_ptr} + (VC_ID_W+1)'(k);
            if (w_sum >= (VC_ID_W+1)'(N)) begin
                w_sum = w_sum - (VC_ID_W+1)'(N);
            end
            if (i_en && !w_found && i_req[w_sum[VC_ID_W-1:0]]) begin
                w_found                      = 1'b1;
                o_gnt[w_sum[VC_ID_W-1:0]]    = 1'b1;
                o_idx                        = w_sum[VC_ID_W-1:0];
            end
        end
    end
endmodule

// File: rtl/vc_out_arbiter.sv
// Router input-port output stage: round-robin over VC head flits with wormhole
// lock, feeding a single valid/ready output register.
//
//   state       | meaning
//   ST_UNLOCKED | any valid VC may win, round-robin from r_rr_ptr
//   ST_LOCKED   | only r_lock_vc is eligible until its tail flit passes
module vc_out_arbiter #(
    parameter int NUM_VC = 3,
    parameter int FLIT_W = ravenoc_pkg::FLIT_W
) (
    input  logic                     clk,
    input  logic                     arst,
    input  logic [NUM_VC*FLIT_W-1:0] fdata_i,
    input  logic [NUM_VC-1:0]        valid_i,
    output logic [NUM_VC-1:0]        ready_o,
    output logic [FLIT_W-1:0]        fdata_o,
    output logic [1:0]               vc_id_o,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic                     error_o
);
    import ravenoc_pkg::*;

    arb_state_t           r_state, w_state_nxt;
    logic [VC_ID_W-1:0]   r_lock_vc, w_lock_vc_nxt;
    logic [VC_ID_W-1:0]   r_rr_ptr, w_rr_ptr_nxt;
    logic [FLIT_W-1:0]    r_fdata;
    logic [VC_ID_W-1:0]   r_vc_id;
    logic                 r_valid;
    logic                 r_error;

    logic                 w_ld;
    logic [NUM_VC-1:0]    w_req;
    logic [NUM_VC-1:0]    w_gnt;
    logic [VC_ID_W-1:0]   w_gidx;
    logic                 w_any;
    logic [FLIT_W-1:0]    w_flit;
    logic [1:0]           w_ftype;
    logic [7:0]           w_fsize;
    logic                 w_err;

    assign w_ld = !r_valid || ready_i;

    always_comb begin
        w_req = valid_i;
        if (r_state == ST_LOCKED) begin
            w_req            = '0;
            w_req[r_lock_vc] = valid_i[r_lock_vc];
        end
    end

    rr_arbiter #(.N(NUM_VC)) u_rr_arbiter (
        .i_req (w_req),
        .i_ptr (r_rr_ptr),
        .i_en  (w_ld),
        .o_gnt (w_gnt),
        .o_idx (w_gidx)
    );

    assign w_any   = |w_gnt;
    assign w_flit  = fdata_i[w_gidx*FLIT_W +: FLIT_W];
    assign w_ftype = w_flit[TYPE_MSB:TYPE_LSB];
    assign w_fsize = w_flit[SIZE_MSB:SIZE_LSB];

    always_comb begin
        w_state_nxt   = r_state;
        w_lock_vc_nxt = r_lock_vc;
        w_rr_ptr_nxt  = r_rr_ptr;
        w_err         = 1'b0;
        if (w_any) begin
            case (w_ftype)
                HEAD_FLIT: begin
                    if (r_state == ST_UNLOCKED) begin
                        w_rr_ptr_nxt = (w_gidx == VC_ID_W'(NUM_VC-1)) ? '0 : w_gidx + 2'd1;
                        if (w_fsize != 8'd0) begin
                            w_state_nxt   = ST_LOCKED;
                            w_lock_vc_nxt = w_gidx;
                        end
                    end else begin
                        w_err = 1'b1;
                    end
                end
                BODY_FLIT: w_err = (r_state == ST_UNLOCKED);
                TAIL_FLIT: begin
                    if (r_state == ST_UNLOCKED) w_err = 1'b1;
                    else                        w_state_nxt = ST_UNLOCKED;
                end
                default: w_err = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            r_state   <= ST_UNLOCKED;
            r_lock_vc <= '0;
            r_rr_ptr  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_lock_vc <= w_lock_vc_nxt;
            r_rr_ptr  <= w_rr_ptr_nxt;
        end
    end

    // error_o pulses with the flit's first appearance, even if the output then stalls
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            r_valid <= 1'b0;
            r_fdata <= '0;
            r_vc_id <= '0;
            r_error <= 1'b0;
        end else begin
            r_error <= w_any && w_err;
            if (w_ld) begin
                r_valid <= w_any;
                if (w_any) begin
                    r_fdata <= w_flit;
                    r_vc_id <= w_gidx;
                end
            end
        end
    end

    assign ready_o = w_gnt;
    assign fdata_o = r_fdata;
    assign vc_id_o = r_vc_id;
    assign valid_o = r_valid;
    assign error_o = r_error;
endmodule

// File: tb/tb_vc_out_arbiter.sv
// Directed bench for vc_out_arbiter: expected flits are queued when granted and
// compared when they reach the output register.
module tb_vc_out_arbiter;
    localparam int NUM_VC = 3;
    localparam int FLIT_W = 34;

    logic                     clk;
    logic                     arst;
    logic [NUM_VC*FLIT_W-1:0] fdata_i;
    logic [NUM_VC-1:0]        valid_i;
    logic [NUM_VC-1:0]        ready_o;
    logic [FLIT_W-1:0]        fdata_o;
    logic [1:0]               vc_id_o;
    logic                     valid_o;
    logic                     ready_i;
    logic                     error_o;

    vc_out_arbiter #(.NUM_VC(NUM_VC), .FLIT_W(FLIT_W)) dut (
        .clk     (clk),
        .arst    (arst),
        .fdata_i (fdata_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .fdata_o (fdata_o),
        .vc_id_o (vc_id_o),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .error_o (error_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [FLIT_W-1:0] flit;
        logic [1:0]        vc;
        logic              err;
    } exp_t;

    exp_t              sb[$];
    int                checks = 0;
    int                errors = 0;
    logic [FLIT_W-1:0] last_flit = '0;
    logic [1:0]        last_vc = '0;

    localparam logic [1:0] T_HEAD = 2'b00;
    localparam logic [1:0] T_BODY = 2'b01;
    localparam logic [1:0] T_TAIL = 2'b11;
    localparam logic [1:0] T_RSVD = 2'b10;

    function automatic logic [FLIT_W-1:0] mkflit(input logic [1:0] t, input logic [7:0] sz,
                                                 input logic [21:0] pl);
        return {t, 2'b00, sz, pl};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_vc(input int v, input logic [FLIT_W-1:0] f);
        fdata_i[v*FLIT_W +: FLIT_W] = f;
    endtask

    // Inputs are set just after a rising edge; ready_o is checked mid-cycle,
    // the registered result just after the next edge.
    task automatic cycle(input logic [2:0] exp_rdy, input logic exp_err, input string tag);
        exp_t e;
        logic ri;
        int   g;
        #3;
        check({tag, "/ready_o"}, 64'(ready_o), 64'(exp_rdy));
        if (exp_rdy != 3'b000) begin
            g      = (exp_rdy == 3'b001) ? 0 : (exp_rdy == 3'b010) ? 1 : 2;
            e.flit = fdata_i[g*FLIT_W +: FLIT_W];
            e.vc   = 2'(g);
            e.err  = exp_err;
            sb.push_back(e);
        end
        ri = ready_i;
        @(posedge clk);
        #1;
        if (exp_rdy != 3'b000) begin
            e = sb.pop_front();
            check({tag, "/valid_o"}, 64'(valid_o), 64'(1'b1));
            check({tag, "/fdata_o"}, 64'(fdata_o), 64'(e.flit));
            check({tag, "/vc_id_o"}, 64'(vc_id_o), 64'(e.vc));
            check({tag, "/error_o"}, 64'(error_o), 64'(e.err));
            last_flit = e.flit;
            last_vc   = e.vc;
        end else begin
            check({tag, "/error_o"}, 64'(error_o), 64'(1'b0));
            if (ri) begin
                check({tag, "/valid_o_idle"}, 64'(valid_o), 64'(1'b0));
            end else begin
                check({tag, "/valid_o_hold"}, 64'(valid_o), 64'(1'b1));
                check({tag, "/fdata_o_hold"}, 64'(fdata_o), 64'(last_flit));
                check({tag, "/vc_id_o_hold"}, 64'(vc_id_o), 64'(last_vc));
            end
        end
    endtask

    initial begin
        arst    = 1'b0;
        ready_i = 1'b1;
        valid_i = '0;
        fdata_i = '0;
        #2;
        check("rst/valid_o", 64'(valid_o), 64'(1'b0));
        check("rst/fdata_o", 64'(fdata_o), 64'(0));
        check("rst/vc_id_o", 64'(vc_id_o), 64'(0));
        check("rst/error_o", 64'(error_o), 64'(1'b0));
        check("rst/ready_o", 64'(ready_o), 64'(0));
        @(posedge clk);
        @(posedge clk);
        #1;
        arst = 1'b1;

        // single-flit head from VC0
        set_vc(0, mkflit(T_HEAD, 8'd0, 22'h11));
        valid_i = 3'b001;
        cycle(3'b001, 1'b0, "single_head");

        // VC1 multi-flit packet locks out VC0/VC2 (pointer now 1)
        valid_i = 3'b111;
        set_vc(0, mkflit(T_HEAD, 8'd0, 22'h20));
        set_vc(2, mkflit(T_HEAD, 8'd0, 22'h22));
        set_vc(1, mkflit(T_HEAD, 8'd3, 22'h100));
        cycle(3'b010, 1'b0, "pkt_head");
        set_vc(1, mkflit(T_BODY, 8'd0, 22'h101));
        cycle(3'b010, 1'b0, "pkt_body0");
        set_vc(1, mkflit(T_BODY, 8'd0, 22'h102));
        cycle(3'b010, 1'b0, "pkt_body1");
        set_vc(1, mkflit(T_TAIL, 8'd0, 22'h103));
        cycle(3'b010, 1'b0, "pkt_tail");
        valid_i = 3'b101;
        cycle(3'b100, 1'b0, "after_tail");

        // full-rate streaming, pointer now 0
        valid_i = 3'b111;
        for (int i = 0; i < 6; i++) begin
            for (int v = 0; v < NUM_VC; v++) begin
                set_vc(v, mkflit(T_HEAD, 8'd0, 22'(32'h200 + i*4 + v)));
            end
            cycle(3'(1 << (i % 3)), 1'b0, "stream");
        end

        // back-pressure in the middle of a VC0 packet
        valid_i = 3'b011;
        set_vc(0, mkflit(T_HEAD, 8'd2, 22'h300));
        set_vc(1, mkflit(T_HEAD, 8'd0, 22'h310));
        cycle(3'b001, 1'b0, "stall_head");
        ready_i = 1'b0;
        set_vc(0, mkflit(T_BODY, 8'd0, 22'h301));
        for (int i = 0; i < 3; i++) begin
            cycle(3'b000, 1'b0, "stall");
        end
        ready_i = 1'b1;
        cycle(3'b001, 1'b0, "stall_body");
        set_vc(0, mkflit(T_TAIL, 8'd0, 22'h302));
        cycle(3'b001, 1'b0, "stall_tail");
        valid_i = 3'b010;
        cycle(3'b010, 1'b0, "post_stall");

        // protocol errors: stray body, reserved type, head inside a locked packet
        valid_i = 3'b100;
        set_vc(2, mkflit(T_BODY, 8'd0, 22'h400));
        cycle(3'b100, 1'b1, "body_unlocked");
        valid_i = 3'b000;
        cycle(3'b000, 1'b0, "idle");
        valid_i = 3'b011;
        set_vc(0, mkflit(T_HEAD, 8'd0, 22'h410));
        set_vc(1, mkflit(T_HEAD, 8'd0, 22'h411));
        cycle(3'b001, 1'b0, "no_lock_after_body");
        valid_i = 3'b010;
        set_vc(1, mkflit(T_RSVD, 8'd0, 22'h420));
        cycle(3'b010, 1'b1, "reserved");
        valid_i = 3'b110;
        set_vc(2, mkflit(T_HEAD, 8'd0, 22'h431));
        set_vc(1, mkflit(T_HEAD, 8'd1, 22'h430));
        cycle(3'b010, 1'b0, "lock_head");
        set_vc(1, mkflit(T_HEAD, 8'd1, 22'h432));
        cycle(3'b010, 1'b1, "head_in_lock");
        set_vc(1, mkflit(T_TAIL, 8'd0, 22'h433));
        cycle(3'b010, 1'b0, "lock_tail");

        // asynchronous reset while LOCKED(1) with a flit in the output register
        valid_i = 3'b010;
        set_vc(1, mkflit(T_HEAD, 8'd2, 22'h500));
        cycle(3'b010, 1'b0, "pre_reset_head");
        #1;
        arst = 1'b0;
        #1;
        check("async_rst/valid_o", 64'(valid_o), 64'(1'b0));
        check("async_rst/fdata_o", 64'(fdata_o), 64'(0));
        check("async_rst/error_o", 64'(error_o), 64'(1'b0));
        sb.delete();
        valid_i = 3'b011;
        set_vc(0, mkflit(T_HEAD, 8'd0, 22'h510));
        set_vc(1, mkflit(T_BODY, 8'd0, 22'h501));
        @(posedge clk);
        #1;
        arst = 1'b1;
        cycle(3'b001, 1'b0, "post_reset_head");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
